spi_norflash_responder: RTL and testbench

Synthesizable SPI NOR flash responder: the device end of the SPI link driven by the team's APB-to-SPI NOR flash controller. It oversamples the SPI pins with the system clock, decodes a subset of the standard NOR command set and serves a small on-chip byte array with NOR semantics (program clears bits, erase sets bytes to 0xFF). It is used as the flash model in controller benches and as a loopback target on FPGA.

---
 rtl/spi_norflash_responder_if.sv | 17 +
 rtl/spi_norflash_responder.sv | 255 +++++++++++++++++++++++++
 tb/tb_spi_norflash_responder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_norflash_responder_if.sv
// SPI NOR flash pin bundle between a controller and the responder.
//   s_clk   : SPI clock, mode 0 (idle low), driven by the controller
//   s_css   : chip select, active-low, driven by the controller
//   s_mosi  : serial command/address/data to the flash, MSB first
//   s_miso  : serial read data from the flash, MSB first
//   busy    : flash-side mirror of the status WIP bit
`timescale 1ns/1ps
interface spi_norflash_responder_if;
    logic s_clk;
    logic s_css;
    logic s_mosi;
    logic s_miso;
    logic busy;

    modport master (output s_clk, output s_css, output s_mosi, input s_miso, input busy);
    modport slave  (input s_clk, input s_css, input s_mosi, output s_miso, output busy);
endinterface

// File: rtl/spi_norflash_responder.sv
// SPI NOR flash responder: oversamples the SPI pins with p_clk, decodes WREN/WRDI/RDSR/READ/PP/SE
// and serves a 2^ADDR_W byte array with NOR semantics (program ANDs bits, erase sets 0xFF).
//   p_clk   : system clock, at least 8x the SPI clock
//   p_reset : asynchronous reset, active-high (array contents are kept)
//   spi     : slave modport carrying s_clk/s_css/s_mosi in and s_miso/busy out
`timescale 1ns/1ps
module spi_norflash_responder #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned PAGE_W   = 4,
    parameter int unsigned SECTOR_W = 6
) (
    input logic                     p_clk,
    input logic                     p_reset,
    spi_norflash_responder_if.slave spi
);
    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PageMask   = ADDR_W'((1 << PAGE_W) - 1);
    localparam logic [ADDR_W-1:0] SectorMask = ADDR_W'((1 << SECTOR_W) - 1);

    localparam logic [7:0] OpWren = 8'h06;
    localparam logic [7:0] OpWrdi = 8'h04;
    localparam logic [7:0] OpRdsr = 8'h05;
    localparam logic [7:0] OpRead = 8'h03;
    localparam logic [7:0] OpPp   = 8'h02;
    localparam logic [7:0] OpSe   = 8'h20;

    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StDataOut, StDataIn, StEraseWait, StIgnore
    } state_e;

    // Pin synchronizers and registered edge strobes
    logic [1:0] sclk_sync_q, css_sync_q;
    logic [2:0] mosi_sync_q;  // one stage deeper so the sampled bit lines up with the strobe
    logic       sclk_dly_q, css_dly_q;
    logic       sclk_rise_q, sclk_fall_q, css_rise_q, css_fall_q;
    logic       sclk_rise_d, sclk_fall_d, css_rise_d, css_fall_d;

    state_e              state_q, state_d;
    logic [7:0]          shift_q, shift_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [2:0]          byte_cnt_q, byte_cnt_d;   // saturates at 7
    logic [7:0]          cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          tx_q, tx_d;
    logic                miso_q, miso_d;
    logic                wel_q, wel_d;
    logic                wip_q, wip_d;
    logic                pp_wrote_q, pp_wrote_d;
    logic [ADDR_W-1:0]   erase_addr_q, erase_addr_d;
    logic [SECTOR_W-1:0] erase_cnt_q, erase_cnt_d;

    logic [7:0]        mem_q [Depth];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    logic       mosi_bit, byte_done;
    logic [7:0] rx_byte, mem_rdata, load_byte;

    assign mosi_bit  = mosi_sync_q[2];
    assign byte_done = (bit_cnt_q == 3'd7);
    assign rx_byte   = {shift_q[6:0], mosi_bit};
    assign mem_rdata = mem_q[addr_q];

    assign sclk_rise_d = sclk_sync_q[1] & ~sclk_dly_q;
    assign sclk_fall_d = ~sclk_sync_q[1] & sclk_dly_q;
    assign css_rise_d  = css_sync_q[1] & ~css_dly_q;
    assign css_fall_d  = ~css_sync_q[1] & css_dly_q;

    // State register
    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            sclk_sync_q  <= 2'b00;
            css_sync_q   <= 2'b11;
            mosi_sync_q  <= 3'b000;
            sclk_dly_q   <= 1'b0;
            css_dly_q    <= 1'b1;
            sclk_rise_q  <= 1'b0;
            sclk_fall_q  <= 1'b0;
            css_rise_q   <= 1'b0;
            css_fall_q   <= 1'b0;
            state_q      <= StIdle;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= 3'd0;
            cmd_q        <= 8'h00;
            addr_q       <= '0;
            tx_q         <= 8'h00;
            miso_q       <= 1'b0;
            wel_q        <= 1'b0;
            wip_q        <= 1'b0;
            pp_wrote_q   <= 1'b0;
            erase_addr_q <= '0;
            erase_cnt_q  <= '0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[0], spi.s_clk};
            css_sync_q   <= {css_sync_q[0], spi.s_css};
            mosi_sync_q  <= {mosi_sync_q[1:0], spi.s_mosi};
            sclk_dly_q   <= sclk_sync_q[1];
            css_dly_q    <= css_sync_q[1];
            sclk_rise_q  <= sclk_rise_d;
            sclk_fall_q  <= sclk_fall_d;
            css_rise_q   <= css_rise_d;
            css_fall_q   <= css_fall_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            tx_q         <= tx_d;
            miso_q       <= miso_d;
            wel_q        <= wel_d;
            wip_q        <= wip_d;
            pp_wrote_q   <= pp_wrote_d;
            erase_addr_q <= erase_addr_d;
            erase_cnt_q  <= erase_cnt_d;
        end
    end

    // Array: deliberately not reset
    always_ff @(posedge p_clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Next-state logic; chip-select events take priority over a coincident clock edge
    always_comb begin
        state_d = state_q;
        if (css_fall_q) begin
            state_d = StCmd;
        end else if (css_rise_q) begin
            state_d = StIdle;
        end else if (sclk_rise_q && byte_done) begin
            case (state_q)
                StCmd: begin
                    if (wip_q && rx_byte != OpRdsr) begin
                        state_d = StIgnore;
                    end else begin
                        case (rx_byte)
                            OpRdsr:             state_d = StDataOut;
                            OpRead, OpPp, OpSe: state_d = StAddr;
                            default:            state_d = StIgnore;  // WREN/WRDI done, unknown
                        endcase
                    end
                end
                StAddr: begin
                    if (byte_cnt_q == 3'd3) begin
                        case (cmd_q)
                            OpRead:  state_d = StDataOut;
                            OpPp:    state_d = StDataIn;
                            default: state_d = StEraseWait;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath, status bits, erase engine and array write port
    always_comb begin
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        tx_d         = tx_q;
        miso_d       = miso_q;
        wel_d        = wel_q;
        wip_d        = wip_q;
        pp_wrote_d   = pp_wrote_q;
        erase_addr_d = erase_addr_q;
        erase_cnt_d  = erase_cnt_q;
        mem_we       = 1'b0;
        mem_waddr    = addr_q;
        mem_wdata    = 8'hFF;
        load_byte    = 8'h00;

        // Erase runs independently of any transaction, one byte per cycle
        if (wip_q) begin
            mem_we      = 1'b1;
            mem_waddr   = erase_addr_q | ADDR_W'(erase_cnt_q);
            mem_wdata   = 8'hFF;
            erase_cnt_d = erase_cnt_q + 1'b1;
            if (erase_cnt_q == '1) begin
                wip_d = 1'b0;
                wel_d = 1'b0;
            end
        end

        if (css_fall_q) begin
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 3'd0;
            pp_wrote_d = 1'b0;
            miso_d     = 1'b0;
        end else if (css_rise_q) begin
            miso_d = 1'b0;
            // Erase only when exactly opcode + 24 address bits were clocked in
            if (state_q == StEraseWait && byte_cnt_q == 3'd4 && bit_cnt_q == 3'd0 && wel_q) begin
                wip_d        = 1'b1;
                erase_cnt_d  = '0;
                erase_addr_d = addr_q & ~SectorMask;
            end
            if (state_q == StDataIn && pp_wrote_q) begin
                wel_d = 1'b0;
            end
        end else if (sclk_rise_q && state_q != StIdle) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (byte_done && byte_cnt_q != 3'd7) begin
                byte_cnt_d = byte_cnt_q + 3'd1;
            end
            case (state_q)
                StCmd: begin
                    if (byte_done) begin
                        cmd_d = rx_byte;
                        if (!wip_q && rx_byte == OpWren) wel_d = 1'b1;
                        if (!wip_q && rx_byte == OpWrdi) wel_d = 1'b0;
                    end
                end
                StAddr: addr_d = {addr_q[ADDR_W-2:0], mosi_bit};
                StDataIn: begin
                    if (byte_done && wel_q) begin
                        mem_we     = 1'b1;
                        mem_waddr  = addr_q;
                        mem_wdata  = mem_rdata & rx_byte;
                        // Wrap inside the current page
                        addr_d     = (addr_q & ~PageMask) | ((addr_q + ADDR_W'(1)) & PageMask);
                        pp_wrote_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (sclk_fall_q && state_q == StDataOut) begin
            if (bit_cnt_q == 3'd0) begin
                // Byte boundary: recapture status (live WIP) or fetch the next array byte
                load_byte = (cmd_q == OpRead) ? mem_rdata : {6'b0, wel_q, wip_q};
                miso_d    = load_byte[7];
                tx_d      = {load_byte[6:0], 1'b0};
                if (cmd_q == OpRead) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end else begin
                miso_d = tx_q[7];
                tx_d   = {tx_q[6:0], 1'b0};
            end
        end
    end

    // Outputs
    assign spi.s_miso = miso_q;
    assign spi.busy   = wip_q;
endmodule

// File: tb/tb_spi_norflash_responder.sv
// Self-checking bench for spi_norflash_responder: drives SPI transactions and compares the
// returned bytes, busy timing and status against a byte-array/WEL reference model.
`timescale 1ns/1ps
module tb_spi_norflash_responder;
    logic p_clk = 1'b0;
    logic p_reset;
    always #5 p_clk = ~p_clk;

    spi_norflash_responder_if spi ();

    spi_norflash_responder #(
        .ADDR_W   (8),
        .PAGE_W   (4),
        .SECTOR_W (6)
    ) dut (
        .p_clk   (p_clk),
        .p_reset (p_reset),
        .spi     (spi)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ref_mem [256];
    bit         ref_wel;
    logic [7:0] tx_bytes [$];
    logic [7:0] rx_bytes [$];
    logic [7:0] pp_data  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge p_clk);
    endtask

    // One transaction; the first fast_bits bits use a 4-cycle SPI period, the rest 16 cycles.
    // Returns with s_css just raised.
    task automatic spi_xfer(input int nbits, input int fast_bits);
        logic [7:0] cur;
        logic [7:0] b;
        int half;
        rx_bytes.delete();
        cur = 8'h00;
        spi.s_css = 1'b0;
        idle(4);
        for (int i = 0; i < nbits; i++) begin
            half = (i < fast_bits) ? 2 : 8;
            b = (i / 8 < tx_bytes.size()) ? tx_bytes[i / 8] : 8'h00;
            spi.s_mosi = b[7 - (i % 8)];
            idle(half);
            cur = {cur[6:0], spi.s_miso};
            spi.s_clk = 1'b1;
            idle(half);
            spi.s_clk = 1'b0;
            if (i % 8 == 7) rx_bytes.push_back(cur);
        end
        idle(4);
        spi.s_css = 1'b1;
    endtask

    task automatic set_cmd(input logic [7:0] op, input logic [23:0] addr, input bit with_addr);
        tx_bytes.delete();
        tx_bytes.push_back(op);
        if (with_addr) begin
            tx_bytes.push_back(addr[23:16]);
            tx_bytes.push_back(addr[15:8]);
            tx_bytes.push_back(addr[7:0]);
        end
    endtask

    task automatic do_rdsr(input string tag, input int nbytes);
        set_cmd(8'h05, 24'h0, 1'b0);
        spi_xfer(8 + 8 * nbytes, 0);
        idle(4);
        for (int k = 0; k < nbytes; k++) check(tag, rx_bytes[k + 1], {30'b0, ref_wel, 1'b0});
    endtask

    task automatic do_wren();
        set_cmd(8'h06, 24'h0, 1'b0);
        spi_xfer(8, 0);
        idle(4);
        ref_wel = 1'b1;
    endtask

    task automatic do_wrdi();
        set_cmd(8'h04, 24'h0, 1'b0);
        spi_xfer(8, 0);
        idle(4);
        ref_wel = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [23:0] addr, input int n);
        logic [7:0] a;
        set_cmd(8'h03, addr, 1'b1);
        spi_xfer(32 + 8 * n, 0);
        idle(4);
        a = addr[7:0];
        for (int i = 0; i < n; i++) begin
            check(tag, rx_bytes[4 + i], ref_mem[a]);
            a = a + 8'd1;
        end
    endtask

    // Programs pp_data at addr; model: AND into the array, wrap inside a 16-byte page
    task automatic do_pp(input logic [23:0] addr);
        logic [7:0] a;
        set_cmd(8'h02, addr, 1'b1);
        foreach (pp_data[i]) tx_bytes.push_back(pp_data[i]);
        spi_xfer(32 + 8 * pp_data.size(), 0);
        idle(4);
        if (ref_wel) begin
            a = addr[7:0];
            foreach (pp_data[i]) begin
                ref_mem[a] = ref_mem[a] & pp_data[i];
                a = (a & 8'hF0) | ((a + 8'd1) & 8'h0F);
            end
            if (pp_data.size() > 0) ref_wel = 1'b0;
        end
    endtask

    // mode 0: check busy latency/length; 1: RDSR while erasing; 2: reset 10 cycles in
    task automatic do_se(input logic [23:0] addr, input int nbits, input int mode);
        int lat;
        int dur;
        bit exec;
        logic [7:0] base;
        exec = ref_wel && (nbits == 32);
        base = addr[7:0] & 8'hC0;
        set_cmd(8'h20, addr, 1'b1);
        spi_xfer(nbits, 0);
        lat = 0;
        while (!spi.busy && lat < 20) begin
            idle(1);
            lat++;
        end
        if (!exec) begin
            check("se_ignored_busy", spi.busy, 0);
            idle(4);
            return;
        end
        check("se_busy_latency", lat, 4);
        if (mode == 2) begin
            idle(10);
            p_reset = 1'b1;
            #1;
            check("reset_mid_erase_busy", spi.busy, 0);
            idle(2);
            p_reset = 1'b0;
            idle(4);
            for (int i = 0; i < 10; i++) ref_mem[base + 8'(i)] = 8'hFF;
            ref_wel = 1'b0;
            return;
        end
        if (mode == 1) begin
            set_cmd(8'h05, 24'h0, 1'b0);
            spi_xfer(16, 8);
            check("rdsr_during_erase", rx_bytes[1], 8'h03);
        end
        dur = 0;
        while (spi.busy && dur < 200) begin
            idle(1);
            dur++;
        end
        if (mode == 0) check("se_busy_length", dur, 64);
        else check("se_busy_cleared", spi.busy, 0);
        idle(4);
        for (int i = 0; i < 64; i++) ref_mem[base + 8'(i)] = 8'hFF;
        ref_wel = 1'b0;
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] acc;
        spi.s_clk  = 1'b0;
        spi.s_css  = 1'b1;
        spi.s_mosi = 1'b0;
        ref_wel    = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'hxx;
        p_reset = 1'b1;
        idle(3);
        p_reset = 1'b0;
        idle(4);
        check("reset_busy", spi.busy, 0);
        check("reset_miso", spi.s_miso, 0);

        do_rdsr("rdsr_after_reset", 2);
        do_wren();
        do_rdsr("rdsr_wren", 2);
        do_wrdi();
        do_rdsr("rdsr_wrdi", 1);

        // Bring the whole array to a known erased state
        for (int s = 0; s < 4; s++) begin
            do_wren();
            do_se(24'(s * 64), 32, (s == 1) ? 1 : 0);
        end
        do_rdsr("rdsr_after_erase", 1);
        do_read("read_erased_sector", 24'h000040, 64);

        // Page program with wrap inside the page
        do_wren();
        pp_data = '{8'hA5, 8'h3C, 8'h0F};
        do_pp(24'h00004E);
        do_read("pp_wrap_read", 24'h00004E, 3);
        do_read("pp_wrap_low", 24'h000040, 1);
        do_rdsr("rdsr_after_pp", 1);
        do_wren();
        pp_data = '{8'hF0};
        do_pp(24'h00004E);
        do_read("pp_and_bits", 24'h00004E, 1);

        // Writes without WEL are dropped
        pp_data = '{8'h00};
        do_pp(24'h000041);
        do_read("pp_no_wel", 24'h000041, 1);
        do_wren();
        do_se(24'h000040, 33, 0);
        do_rdsr("rdsr_se_33_bits", 1);
        do_wrdi();
        do_se(24'h000040, 32, 0);
        do_read("se_aborted_contents", 24'h00004C, 4);

        // Random data into sectors 2 and 3, one page per program
        for (int p = 0; p < 8; p++) begin
            pp_data.delete();
            for (int i = 0; i < 16; i++) pp_data.push_back(8'($urandom_range(0, 255)));
            do_wren();
            do_pp(24'(8'h80 + 8'(p * 16) + 8'($urandom_range(0, 15))));
        end
        do_read("random_sector2", 24'h000080, 32);
        for (int r = 0; r < 3; r++) begin
            a = 8'($urandom_range(0, 255));
            do_read("random_read", {16'($urandom), a}, 12);
        end
        do_read("read_addr_wrap", 24'hFFFFFA, 12);

        // Unknown opcode keeps s_miso low
        set_cmd(8'hAB, 24'h123456, 1'b1);
        spi_xfer(48, 0);
        idle(4);
        acc = 8'h00;
        foreach (rx_bytes[i]) acc = acc | rx_bytes[i];
        check("unknown_opcode_miso", acc, 8'h00);

        // Reset partway through an erase of randomly filled data
        do_wren();
        do_se(24'h000080, 32, 2);
        do_rdsr("rdsr_after_reset_erase", 1);
        do_read("reset_erase_contents", 24'h000080, 20);

        // Deselect in the middle of a read byte
        set_cmd(8'h03, 24'h000050, 1'b1);
        spi_xfer(43, 0);
        idle(4);
        check("miso_after_abort", spi.s_miso, 0);
        do_rdsr("rdsr_after_abort", 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
